// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues single-outstanding word fetches over a valid/ready
// channel, and holds the IF/ID register feeding decode (with a one-entry park buffer).
//
// state  | meaning
// S_REQ  | fetch request for pc pending on the imem request channel
// S_WAIT | one request in flight, waiting for imem_rsp_valid
// S_BUF  | response parked because IF/ID was full and decode stalled
module fetch_stage #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] PC_RESET = 32'h0100_0000
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          id_stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          if_id_valid,
  output logic [31:0]   if_id_inst,
  output logic [AW-1:0] if_id_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_BUF} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          drop_q, drop_d;
  logic          buf_valid_q, buf_valid_d;
  logic [31:0]   buf_inst_q, buf_inst_d;
  logic [AW-1:0] buf_pc_q, buf_pc_d;
  logic          if_id_valid_q, if_id_valid_d;
  logic [31:0]   if_id_inst_q, if_id_inst_d;
  logic [AW-1:0] if_id_pc_q, if_id_pc_d;
  logic          req_fire;
  logic          if_id_free;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= PC_RESET;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_inst_q    <= 32'h0000_0013;
      buf_pc_q      <= '0;
      if_id_valid_q <= 1'b0;
      if_id_inst_q  <= 32'h0000_0013;
      if_id_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      buf_valid_q   <= buf_valid_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    buf_valid_d   = buf_valid_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;

    // A redirect gates the request so the old address can never be accepted.
    imem_req_valid = (state_q == S_REQ) && !redirect_valid && !reset;
    req_fire       = imem_req_valid && imem_req_ready;
    if_id_free     = !if_id_valid_q || !id_stall;

    if (redirect_valid) begin
      pc_d          = {redirect_pc[AW-1:2], 2'b00};
      if_id_valid_d = 1'b0;
      buf_valid_d   = 1'b0;
      case (state_q)
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      if (if_id_valid_q && !id_stall) if_id_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            inflight_pc_d = pc_q;
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = inflight_pc_q + AW'(4);
              if (if_id_free) begin
                if_id_valid_d = 1'b1;
                if_id_inst_d  = imem_rsp_data;
                if_id_pc_d    = inflight_pc_q;
              end else begin
                buf_valid_d = 1'b1;
                buf_inst_d  = imem_rsp_data;
                buf_pc_d    = inflight_pc_q;
                state_d     = S_BUF;
              end
            end
          end
        end
        S_BUF: begin
          if (!id_stall) begin
            if_id_valid_d = buf_valid_q;
            if_id_inst_d  = buf_inst_q;
            if_id_pc_d    = buf_pc_q;
            buf_valid_d   = 1'b0;
            state_d       = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_pc    = if_id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, checked against a
// transaction-level model (expected fetch PC, flush epochs, queue of pending deliveries).
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  logic        stall_i = 1'b0, redir_i = 1'b0, ready_i = 1'b0;
  logic [31:0] redir_pc_i = 32'h0;
  int          lat_lo = 0, lat_hi = 0;

  // imem responder
  bit          out_busy = 1'b0;
  logic [31:0] out_addr = 32'h0;
  int          out_tag = 0, out_lat = 0;

  // reference model
  logic [31:0] exp_pc = 32'h0100_0000;
  int          epoch = 0;
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  int          hs_count = 0, consumed = 0, idle = 0;
  logic [31:0] last_hs_addr = 32'h0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0100_0000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample before the edge, advance the model, check after.
  task automatic cycle();
    logic        s_req, s_v;
    logic [31:0] s_addr, s_pc, s_inst;
    bit          rsp;
    rsp            = out_busy && (out_lat == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem(out_addr) : $urandom;
    id_stall       = stall_i;
    redirect_valid = redir_i;
    redirect_pc    = redir_pc_i;
    imem_req_ready = ready_i;
    #1;
    s_req = imem_req_valid; s_addr = imem_addr;
    s_v = if_id_valid; s_pc = if_id_pc; s_inst = if_id_inst;

    if (redir_i) chk("req_gated_by_redirect", s_req, 0);
    if (prev_pend) begin
      chk("req_valid_held", s_req, !redir_i);
      if (!redir_i) chk("req_addr_held", s_addr, prev_addr);
    end
    if (s_req) begin
      chk("addr_aligned", s_addr[1:0], 0);
      chk("single_outstanding", out_busy, 0);
    end

    if (s_v && !stall_i && !redir_i) begin
      if (q_pc.size() == 0) chk("consume_unexpected", 1, 0);
      else begin
        chk("consume_pc", s_pc, q_pc[0]);
        chk("consume_inst", s_inst, q_inst[0]);
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
        consumed++;
      end
    end
    if (rsp) begin
      if (out_tag == epoch && !redir_i) begin
        q_pc.push_back(out_addr);
        q_inst.push_back(mem(out_addr));
        exp_pc = out_addr + 32'd4;
      end
      out_busy = 1'b0;
    end else if (out_busy) begin
      out_lat--;
    end
    if (s_req && ready_i) begin
      chk("fetch_addr", s_addr, exp_pc);
      chk("fetch_with_free_slot", q_pc.size() <= 1, 1);
      out_busy = 1'b1; out_addr = s_addr; out_tag = epoch;
      out_lat = $urandom_range(lat_hi, lat_lo);
      hs_count++; last_hs_addr = s_addr; idle = 0;
    end else begin
      idle++;
    end
    if (idle >= 60) begin
      chk("fetch_progress", idle, 0);
      idle = 0;
    end
    if (redir_i) begin
      epoch++;
      q_pc.delete();
      q_inst.delete();
      exp_pc = {redir_pc_i[31:2], 2'b00};
    end
    prev_pend = s_req && !ready_i;
    prev_addr = s_addr;

    @(posedge clock);
    @(negedge clock);
    chk("if_id_valid", if_id_valid, q_pc.size() != 0);
    if (if_id_valid && q_pc.size() != 0) begin
      chk("if_id_pc", if_id_pc, q_pc[0]);
      chk("if_id_inst", if_id_inst, q_inst[0]);
    end
  endtask

  initial begin
    int n;
    // reset state
    @(negedge clock);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_id_valid", if_id_valid, 0);
    chk("rst_if_id_inst", if_id_inst, 32'h0000_0013);
    chk("rst_if_id_pc", if_id_pc, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // T1: first fetch, zero-wait imem
    chk("t1_first_req", imem_req_valid, 1);
    chk("t1_first_addr", imem_addr, 32'h0100_0000);
    ready_i = 1'b1; lat_lo = 0; lat_hi = 0;
    cycle();
    cycle();
    chk("t1_valid", if_id_valid, 1);
    chk("t1_inst", if_id_inst, 32'h0050_0093);
    chk("t1_pc", if_id_pc, 32'h0100_0000);
    chk("t1_next_addr", imem_addr, 32'h0100_0004);

    // T2: stall while a second response arrives
    stall_i = 1'b1;
    n = hs_count;
    repeat (5) cycle();
    chk("t2_one_req", hs_count - n, 1);
    chk("t2_no_third_req", imem_req_valid, 0);
    chk("t2_held_pc", if_id_pc, 32'h0100_0000);
    stall_i = 1'b0;
    repeat (4) cycle();
    chk("t2_delivered", consumed, 3);

    // T3: redirect while a request is in flight
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (out_busy && out_lat >= 1) break;
    end
    redir_i = 1'b1; redir_pc_i = 32'h0100_0103;
    cycle();
    redir_i = 1'b0;
    chk("t3_flushed", if_id_valid, 0);
    n = hs_count;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hs_count > n) break;
    end
    chk("t3_target_addr", last_hs_addr, 32'h0100_0100);

    // T4: redirect coinciding with response and decode stall
    stall_i = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (out_busy && out_lat == 0) break;
    end
    chk("t4_rsp_due", out_busy && out_lat == 0, 1);
    redir_i = 1'b1; redir_pc_i = 32'h0200_0041;
    cycle();
    redir_i = 1'b0; stall_i = 1'b0; lat_lo = 0; lat_hi = 0;
    chk("t4_flushed", if_id_valid, 0);
    n = hs_count;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hs_count > n) break;
    end
    chk("t4_target_addr", last_hs_addr, 32'h0200_0040);

    // T5: imem not ready, then redirect while the request waits
    ready_i = 1'b0;
    repeat (8) cycle();
    chk("t5_req_pending", imem_req_valid, 1);
    redir_i = 1'b1; redir_pc_i = 32'h0000_2008;
    cycle();
    redir_i = 1'b0;
    chk("t5_new_addr", imem_addr, 32'h0000_2008);
    cycle();
    ready_i = 1'b1;
    n = hs_count;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hs_count > n) break;
    end
    chk("t5_accepted_addr", last_hs_addr, 32'h0000_2008);

    // T6: PC wrap at the top of the address space
    redir_i = 1'b1; redir_pc_i = 32'hFFFF_FFFE;
    cycle();
    redir_i = 1'b0;
    n = hs_count;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hs_count > n) break;
    end
    chk("t6_top_addr", last_hs_addr, 32'hFFFF_FFFC);
    n = hs_count;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hs_count > n) break;
    end
    chk("t6_wrap_addr", last_hs_addr, 32'h0000_0000);

    // random traffic
    lat_lo = 0; lat_hi = 3;
    n = consumed;
    for (int i = 0; i < 700; i++) begin
      stall_i    = ($urandom_range(2, 0) == 0);
      ready_i    = ($urandom_range(2, 0) != 0);
      redir_i    = ($urandom_range(15, 0) == 0);
      redir_pc_i = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                               : 32'($urandom);
      cycle();
    end
    stall_i = 1'b0; redir_i = 1'b0; ready_i = 1'b1;
    repeat (20) cycle();
    chk("random_throughput", (consumed - n) >= 60, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
